// File: rtl/request_manager_if.sv
// Button/position inputs and request/lamp outputs of the elevator request manager.
// The slave modport is the request manager's view; master is the driver's view.
interface request_manager_if;
   logic       switch;
   logic [3:0] btn_car;
   logic [2:0] btn_up;
   logic [2:0] btn_dn;
   logic [3:0] position;
   logic       opendoor;
   logic [3:0] allReq_reg;
   logic       up_need;
   logic       down_need;
   logic [3:0] lamp_car;
   logic [2:0] lamp_up;
   logic [2:0] lamp_dn;
   logic [2:0] pend_cnt;

   modport master (
      output switch, btn_car, btn_up, btn_dn, position, opendoor,
      input  allReq_reg, up_need, down_need, lamp_car, lamp_up, lamp_dn, pend_cnt
   );

   modport slave (
      input  switch, btn_car, btn_up, btn_dn, position, opendoor,
      output allReq_reg, up_need, down_need, lamp_car, lamp_up, lamp_dn, pend_cnt
   );
endinterface

// File: rtl/request_manager.sv
// Elevator request manager: latches button rising edges as per-floor requests,
// clears them at the open-door floor, and reports direction needs and pending count.

// One request bit: edge-detected set, clear-wins, held low while disabled or in reset.
module req_bit (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic btn,
   input  logic clr,
   output logic q
);
   logic prev;

   // prev tracks the button even in reset or while disabled, so a held
   // button never looks like a fresh press when the block comes back.
   always_ff @(posedge clk) begin
      prev <= btn;
      if (rst || !en || clr) q <= 1'b0;
      else if (btn && !prev) q <= 1'b1;
   end
endmodule

module request_manager (
   input  logic                    clk,
   input  logic                    rst,
   request_manager_if.slave        bus
);
   logic       onehot;
   logic [3:0] clr_floor;
   logic [3:0] car_q;
   logic [2:0] up_q;
   logic [2:0] dn_q;
   logic [3:0] all_req;
   logic       up_n;
   logic       dn_n;
   logic [2:0] cnt;

   assign onehot    = (bus.position != 4'b0) && ((bus.position & (bus.position - 4'd1)) == 4'b0);
   assign clr_floor = (bus.opendoor && onehot) ? bus.position : 4'b0;

   // up buttons live on floors 1-3, down buttons on floors 2-4
   req_bit u_car [3:0] (.clk(clk), .rst(rst), .en(bus.switch), .btn(bus.btn_car),
                        .clr(clr_floor),      .q(car_q));
   req_bit u_up  [2:0] (.clk(clk), .rst(rst), .en(bus.switch), .btn(bus.btn_up),
                        .clr(clr_floor[2:0]), .q(up_q));
   req_bit u_dn  [2:0] (.clk(clk), .rst(rst), .en(bus.switch), .btn(bus.btn_dn),
                        .clr(clr_floor[3:1]), .q(dn_q));

   assign all_req = car_q | {1'b0, up_q} | {dn_q, 1'b0};

   always_comb begin
      up_n = 1'b0;
      dn_n = 1'b0;
      if (onehot) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.position[i]) begin
               for (int j = 0; j < 4; j++) begin
                  if (j > i) up_n = up_n | all_req[j];
                  if (j < i) dn_n = dn_n | all_req[j];
               end
            end
         end
      end
   end

   always_comb begin
      cnt = 3'd0;
      for (int i = 0; i < 4; i++) cnt = cnt + {2'b0, all_req[i]};
   end

   assign bus.allReq_reg = all_req;
   assign bus.lamp_car   = car_q;
   assign bus.lamp_up    = up_q;
   assign bus.lamp_dn    = dn_q;
   assign bus.up_need    = up_n;
   assign bus.down_need  = dn_n;
   assign bus.pend_cnt   = cnt;
endmodule

// File: tb/tb_request_manager.sv
// Directed scenarios plus randomized traffic for request_manager, checked
// against a floor-indexed behavioural model of pending requests.
module tb_request_manager;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   request_manager_if bus ();
   request_manager dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int n_assert = 0;
   int n_fail   = 0;

   // model state, indexed by floor number 1..4
   bit m_car [5];
   bit m_up  [5];
   bit m_dn  [5];
   bit p_car [5];
   bit p_up  [5];
   bit p_dn  [5];

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic int cur_floor();
      int n = 0;
      int f = 0;
      for (int i = 0; i < 4; i++) if (bus.position[i] === 1'b1) begin n++; f = i + 1; end
      return (n == 1) ? f : 0;
   endfunction

   task automatic model_edge();
      int cur = cur_floor();
      for (int f = 1; f <= 4; f++) begin
         bit nc = bus.btn_car[f-1];
         bit nu = (f <= 3) ? bus.btn_up[f-1] : 1'b0;
         bit nd = (f >= 2) ? bus.btn_dn[f-2] : 1'b0;
         if (rst || !bus.switch) begin
            m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0;
         end else if (bus.opendoor && cur == f) begin
            m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0;
         end else begin
            if (nc && !p_car[f]) m_car[f] = 1;
            if (nu && !p_up[f])  m_up[f]  = 1;
            if (nd && !p_dn[f])  m_dn[f]  = 1;
         end
         p_car[f] = nc; p_up[f] = nu; p_dn[f] = nd;
      end
   endtask

   task automatic check_model();
      logic [3:0] e_all, e_car, e_up, e_dn;
      int cnt = 0;
      int cur = cur_floor();
      bit upn = 0, dnn = 0;
      e_all = '0; e_car = '0; e_up = '0; e_dn = '0;
      for (int f = 1; f <= 4; f++) begin
         bit pend = m_car[f] | m_up[f] | m_dn[f];
         e_all[f-1] = pend;
         e_car[f-1] = m_car[f];
         if (f <= 3) e_up[f-1] = m_up[f];
         if (f >= 2) e_dn[f-2] = m_dn[f];
         if (pend) cnt++;
         if (cur != 0 && pend && f > cur) upn = 1;
         if (cur != 0 && pend && f < cur) dnn = 1;
      end
      chk("m_allReq",   bus.allReq_reg,        e_all);
      chk("m_lamp_car", bus.lamp_car,          e_car);
      chk("m_lamp_up",  {1'b0, bus.lamp_up},   e_up);
      chk("m_lamp_dn",  {1'b0, bus.lamp_dn},   e_dn);
      chk("m_up_need",  {3'b0, bus.up_need},   {3'b0, upn});
      chk("m_down_need",{3'b0, bus.down_need}, {3'b0, dnn});
      chk("m_pend_cnt", {1'b0, bus.pend_cnt},  4'(cnt));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic drive(input logic sw, input logic [3:0] car, input logic [2:0] up,
                        input logic [2:0] dn, input logic [3:0] pos, input logic od);
      bus.switch = sw; bus.btn_car = car; bus.btn_up = up; bus.btn_dn = dn;
      bus.position = pos; bus.opendoor = od;
   endtask

   initial begin
      rst = 1'b1;
      drive(1, 4'b0, 3'b0, 3'b0, 4'b0001, 0);
      tick(); tick();
      chk("rst_allReq", bus.allReq_reg, 4'b0000);
      chk("rst_pend",   {1'b0, bus.pend_cnt}, 4'd0);
      rst = 1'b0;
      tick();

      // pulse car button for floor 3 while at floor 1
      drive(1, 4'b0100, 3'b0, 3'b0, 4'b0001, 0); tick();
      chk("s1_allReq", bus.allReq_reg, 4'b0100);
      chk("s1_up",     {3'b0, bus.up_need},   4'd1);
      chk("s1_down",   {3'b0, bus.down_need}, 4'd0);
      chk("s1_pend",   {1'b0, bus.pend_cnt},  4'd1);
      drive(1, 4'b0000, 3'b0, 3'b0, 4'b0001, 0); tick();

      // door opens at floor 3; held button must not re-request
      drive(1, 4'b0100, 3'b0, 3'b0, 4'b0100, 0); tick();
      drive(1, 4'b0100, 3'b0, 3'b0, 4'b0100, 1); tick();
      chk("s2_clear",  bus.allReq_reg, 4'b0000);
      chk("s2_pend",   {1'b0, bus.pend_cnt}, 4'd0);
      drive(1, 4'b0100, 3'b0, 3'b0, 4'b0100, 0); tick(); tick();
      chk("s2_held",   bus.allReq_reg, 4'b0000);
      drive(1, 4'b0000, 3'b0, 3'b0, 4'b0100, 0); tick();
      drive(1, 4'b0100, 3'b0, 3'b0, 4'b0100, 0); tick();
      chk("s2_repress", bus.allReq_reg, 4'b0100);
      drive(1, 4'b0000, 3'b0, 3'b0, 4'b0100, 1); tick();

      // set and clear collide on floor 2
      drive(1, 4'b1000, 3'b010, 3'b0, 4'b0010, 1); tick();
      chk("s3_allReq", bus.allReq_reg, 4'b1000);
      chk("s3_up",     {3'b0, bus.up_need}, 4'd1);
      drive(1, 4'b0000, 3'b0, 3'b0, 4'b1000, 1); tick();

      // everything pressed, then master switch off and back on with buttons held
      drive(1, 4'b1111, 3'b111, 3'b111, 4'b0001, 0); tick();
      chk("s4_pend4",  {1'b0, bus.pend_cnt}, 4'd4);
      drive(0, 4'b1111, 3'b111, 3'b111, 4'b0001, 0); tick();
      chk("s4_off_car", bus.lamp_car, 4'b0000);
      chk("s4_off_up",  {1'b0, bus.lamp_up}, 4'b0000);
      chk("s4_off_dn",  {1'b0, bus.lamp_dn}, 4'b0000);
      drive(1, 4'b1111, 3'b111, 3'b111, 4'b0001, 0); tick();
      chk("s4_on_held", bus.allReq_reg, 4'b0000);
      chk("s4_on_pend", {1'b0, bus.pend_cnt}, 4'd0);
      drive(1, 4'b0000, 3'b0, 3'b0, 4'b0001, 0); tick();

      // button held through reset release
      drive(1, 4'b0000, 3'b0, 3'b001, 4'b0001, 0);
      rst = 1'b1; tick();
      rst = 1'b0; tick(); tick();
      chk("s5_held_rst", bus.allReq_reg, 4'b0000);
      drive(1, 4'b1010, 3'b0, 3'b000, 4'b0001, 0); tick();
      drive(1, 4'b0000, 3'b0, 3'b000, 4'b0100, 0); tick();
      chk("s5_pre",    bus.allReq_reg, 4'b1010);
      rst = 1'b1; tick();
      chk("s5_rst_all",  bus.allReq_reg, 4'b0000);
      chk("s5_rst_up",   {3'b0, bus.up_need},   4'd0);
      chk("s5_rst_down", {3'b0, bus.down_need}, 4'd0);
      rst = 1'b0; tick();

      // invalid position: no needs, no clearing
      drive(1, 4'b1001, 3'b0, 3'b0, 4'b0100, 0); tick();
      drive(1, 4'b0000, 3'b0, 3'b0, 4'b0000, 0); tick();
      chk("s6_up0",   {3'b0, bus.up_need},   4'd0);
      chk("s6_down0", {3'b0, bus.down_need}, 4'd0);
      chk("s6_pend",  {1'b0, bus.pend_cnt},  4'd2);
      drive(1, 4'b0000, 3'b0, 3'b0, 4'b0000, 1); tick();
      chk("s6_noclr0", bus.allReq_reg, 4'b1001);
      drive(1, 4'b0000, 3'b0, 3'b0, 4'b0110, 1); tick();
      chk("s6_noclr6", bus.allReq_reg, 4'b1001);
      chk("s6_up6",    {3'b0, bus.up_need}, 4'd0);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         logic [3:0] pos;
         case ($urandom_range(0, 9))
            0:       pos = 4'b0000;
            1:       pos = 4'($urandom_range(0, 15));
            default: pos = 4'b0001 << $urandom_range(0, 3);
         endcase
         rst = ($urandom_range(0, 49) == 0);
         drive(($urandom_range(0, 19) != 0),
               ($urandom_range(0, 2) == 0) ? 4'($urandom) : bus.btn_car,
               ($urandom_range(0, 2) == 0) ? 3'($urandom) : bus.btn_up,
               ($urandom_range(0, 2) == 0) ? 3'($urandom) : bus.btn_dn,
               pos, ($urandom_range(0, 3) == 0));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
